// File: rtl/rx_deser_pkg.sv
// Shared types for the serial flit receiver.
// Flit-width fallbacks apply only when the global defines header has not already been read.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 6
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 2
`endif

package rx_deser_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/rx_deser_if.sv
// Link-side and router-side signals of the flit receiver.
// The receiver takes the master modport.
interface rx_deser_if #(
    parameter int FLIT_W = `PAYLOAD_SIZE + `ADDR_SZ
);
    logic              serial_in;
    logic              channel_busy;
    logic              rx_active;
    logic              flit_valid;
    logic [FLIT_W-1:0] flit_out;
    logic              flit_ack;
    logic              overflow;

    modport master (
        input  serial_in,
        input  flit_ack,
        output channel_busy,
        output rx_active,
        output flit_valid,
        output flit_out,
        output overflow
    );

    modport slave (
        output serial_in,
        output flit_ack,
        input  channel_busy,
        input  rx_active,
        input  flit_valid,
        input  flit_out,
        input  overflow
    );
endinterface

// File: rtl/rx_fifo.sv
// Small synchronous flit FIFO with a combinational head output.
// A push into a full FIFO is ignored unless a pop happens on the same edge.
module rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         valid,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign valid   = (count_q != '0);
    assign full    = (count_q == OCC_W'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign dout    = valid ? mem[rd_ptr] : '0;

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/rx_deser.sv
// Serial flit receiver: start-bit detect, LSB-first deserialiser and flit buffer.
//   state   | meaning
//   ST_IDLE | line idle; a sampled 1 is a start bit
//   ST_RECV | shifting in data bits; last bit pushes the flit
module rx_deser
    import rx_deser_pkg::*;
#(
    parameter int FLIT_W   = `PAYLOAD_SIZE + `ADDR_SZ,
    parameter int DEPTH    = 2,
    parameter int routerid = -1,
    parameter     port     = "unknown"
) (
    input  logic       clk,
    input  logic       reset,
    rx_deser_if.master bus
);
    localparam int CNT_W = (FLIT_W > 1) ? $clog2(FLIT_W) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    rx_state_e         state_q;
    rx_state_e         state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [FLIT_W-1:0] shreg_q;
    logic [FLIT_W-1:0] shreg_d;
    logic [FLIT_W-1:0] flit_asm;
    logic              push;
    logic              pop;
    logic              full;
    logic              fifo_valid;
    logic [OCC_W-1:0]  count;
    logic              overflow_q;

    // Shift right with MSB insert: after FLIT_W bits the first bit lands in bit 0
    assign flit_asm = {bus.serial_in, shreg_q[FLIT_W-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.serial_in) begin
                    state_d = ST_RECV;
                    cnt_d   = '0;
                end
            end
            ST_RECV: begin
                shreg_d = flit_asm;
                if (cnt_q == CNT_W'(FLIT_W - 1)) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop = bus.flit_ack & fifo_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (push & full & ~pop) begin
            overflow_q <= 1'b1;
        end
    end

    rx_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (flit_asm),
        .pop   (bus.flit_ack),
        .dout  (bus.flit_out),
        .valid (fifo_valid),
        .full  (full),
        .count (count)
    );

    // The last free slot is reserved for the frame already on the wire
    assign bus.channel_busy = full | ((state_q == ST_RECV) & (count == OCC_W'(DEPTH - 1)));
    assign bus.rx_active    = (state_q == ST_RECV);
    assign bus.flit_valid   = fifo_valid;
    assign bus.overflow     = overflow_q;
endmodule
